// File: rtl/alu_writeback.sv
// ALU writeback stage: registers ALU results into the single register-file write port and holds the CZVN flag register.
// Optional build macro ALU_WB_BYPASS_EN exports same-cycle forwarding ports (fwd_valid/fwd_addr/fwd_data/fwd_pend_hi).
module alu_writeback #(
    parameter int N = 16,
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y,
    input  logic [N-1:0] yhigh,
    input  logic         co,
    input  logic         zero,
    input  logic         overflow,
    input  logic         negative,
    input  logic         use32bit,
    input  logic [A-1:0] dest,
    input  logic         flags_we,
    input  logic         flush,
    output logic         rf_we,
    output logic [A-1:0] rf_waddr,
    output logic [N-1:0] rf_wdata,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_v,
    output logic         flag_n
`ifdef ALU_WB_BYPASS_EN
    ,
    output logic         fwd_valid,
    output logic [A-1:0] fwd_addr,
    output logic [N-1:0] fwd_data,
    output logic         fwd_pend_hi
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;

    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic         pend32_r;
    logic         pend32_nxt_s;
    logic [N-1:0] hi_data_r;
    logic [N-1:0] hi_data_nxt_s;
    logic [A-1:0] hi_addr_r;
    logic [A-1:0] hi_addr_nxt_s;
    logic         we_nxt_s;
    logic [A-1:0] waddr_nxt_s;
    logic [N-1:0] wdata_nxt_s;
    logic         accept_s;
    logic         load_s;

    // High word of a 32-bit pair targets dest+1, wrapping modulo 2^A.
    function automatic logic [A-1:0] next_addr(input logic [A-1:0] a);
        return a + {{(A-1){1'b0}}, 1'b1};
    endfunction

    assign in_ready = !flush && !((state_r == WR_LO) && pend32_r);
    assign accept_s = in_valid && in_ready;

    // Next-state and next write-port values.
    always_comb begin
        state_nxt_s   = IDLE;
        pend32_nxt_s  = pend32_r;
        hi_data_nxt_s = hi_data_r;
        hi_addr_nxt_s = hi_addr_r;
        we_nxt_s      = 1'b0;
        waddr_nxt_s   = rf_waddr;
        wdata_nxt_s   = rf_wdata;
        load_s        = 1'b0;
        if (flush) begin
            state_nxt_s  = IDLE;
            pend32_nxt_s = 1'b0;
        end else begin
            case (state_r)
                WR_LO: begin
                    if (pend32_r) begin
                        state_nxt_s  = WR_HI;
                        we_nxt_s     = 1'b1;
                        waddr_nxt_s  = hi_addr_r;
                        wdata_nxt_s  = hi_data_r;
                        pend32_nxt_s = 1'b0;
                    end else begin
                        load_s = accept_s;
                    end
                end
                IDLE, WR_HI: begin
                    load_s = accept_s;
                end
                default: begin
                    state_nxt_s  = IDLE;
                    pend32_nxt_s = 1'b0;
                end
            endcase
            if (load_s) begin
                state_nxt_s   = WR_LO;
                we_nxt_s      = 1'b1;
                waddr_nxt_s   = dest;
                wdata_nxt_s   = y;
                pend32_nxt_s  = use32bit;
                hi_data_nxt_s = yhigh;
                hi_addr_nxt_s = next_addr(dest);
            end else begin
                hi_data_nxt_s = hi_data_r;
            end
        end
    end

    // Sequencer state and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            pend32_r  <= 1'b0;
            hi_data_r <= {N{1'b0}};
            hi_addr_r <= {A{1'b0}};
            rf_we     <= 1'b0;
            rf_waddr  <= {A{1'b0}};
            rf_wdata  <= {N{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            pend32_r  <= pend32_nxt_s;
            hi_data_r <= hi_data_nxt_s;
            hi_addr_r <= hi_addr_nxt_s;
            rf_we     <= we_nxt_s;
            rf_waddr  <= waddr_nxt_s;
            rf_wdata  <= wdata_nxt_s;
        end
    end

    // Architectural flag register, updated once per accepted result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept_s && flags_we) begin
            flag_c <= co;
            flag_z <= zero;
            flag_v <= overflow;
            flag_n <= negative;
        end else begin
            flag_c <= flag_c;
            flag_z <= flag_z;
            flag_v <= flag_v;
            flag_n <= flag_n;
        end
    end

`ifdef ALU_WB_BYPASS_EN
    assign fwd_valid   = rf_we;
    assign fwd_addr    = rf_waddr;
    assign fwd_data    = rf_wdata;
    assign fwd_pend_hi = (state_r == WR_LO) && pend32_r;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic against a write-queue model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic [15:0] yhigh;
    logic        co, zero, overflow, negative;
    logic        use32bit;
    logic [2:0]  dest;
    logic        flags_we;
    logic        flush;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_c, flag_z, flag_v, flag_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queue of writes still owed, plus the expected visible port and flags.
    logic [18:0] pend_q[$];
    logic        exp_we;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;

    alu_writeback #(.N(16), .A(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .yhigh(yhigh), .co(co), .zero(zero), .overflow(overflow),
        .negative(negative), .use32bit(use32bit), .dest(dest), .flags_we(flags_we),
        .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        return !flush && (pend_q.size() == 0);
    endfunction

    task automatic model_reset();
        pend_q.delete();
        exp_we    = 1'b0;
        exp_addr  = 3'd0;
        exp_data  = 16'd0;
        exp_flags = 4'd0;
    endtask

    // Advance model and DUT by one clock, leaving time at posedge+1.
    task automatic tick();
        logic       acc;
        logic [2:0] ha;
        acc = in_valid && model_ready();
        if (flush) begin
            pend_q.delete();
            exp_we = 1'b0;
        end else if (pend_q.size() > 0) begin
            {exp_addr, exp_data} = pend_q.pop_front();
            exp_we = 1'b1;
        end else if (acc) begin
            exp_we   = 1'b1;
            exp_addr = dest;
            exp_data = y;
            if (use32bit) begin
                ha = dest + 3'd1;
                pend_q.push_back({ha, yhigh});
            end
        end else begin
            exp_we = 1'b0;
        end
        if (acc && flags_we) exp_flags = {co, zero, overflow, negative};
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; y = 16'd0; yhigh = 16'd0; co = 1'b0; zero = 1'b0;
        overflow = 1'b0; negative = 1'b0; use32bit = 1'b0; dest = 3'd0;
        flags_we = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 3'd0 || rf_wdata !== 16'd0) begin
            n_bad++; $display("FAIL reset_port: got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++;
        if ({flag_c, flag_z, flag_v, flag_n} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {flag_c, flag_z, flag_v, flag_n});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle_inputs();
        in_valid = 1'b1; y = 16'h1234; dest = 3'd3; flags_we = 1'b1; co = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
            n_bad++; $display("FAIL single_write: got we=%b a=%0d d=%h want 1/3/1234", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++;
        if ({flag_c, flag_z, flag_v, flag_n} !== 4'b1000) begin
            n_bad++; $display("FAIL single_flags: got %b want 1000", {flag_c, flag_z, flag_v, flag_n});
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
            n_bad++; $display("FAIL single_idle: got we=%b a=%0d d=%h want 0/3/1234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_wide_wrap();
        idle_inputs();
        in_valid = 1'b1; y = 16'h8000; yhigh = 16'hFFFF; dest = 3'd7; use32bit = 1'b1;
        tick();
        // Offer another result during the blocked cycle; it must wait.
        in_valid = 1'b1; y = 16'h00A5; use32bit = 1'b0; dest = 3'd2;
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h8000 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL wide_lo: got we=%b a=%0d d=%h rdy=%b want 1/7/8000/0", rf_we, rf_waddr, rf_wdata, in_ready);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd0 || rf_wdata !== 16'hFFFF || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL wide_hi_wrap: got we=%b a=%0d d=%h rdy=%b want 1/0/FFFF/1", rf_we, rf_waddr, rf_wdata, in_ready);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h00A5) begin
            n_bad++; $display("FAIL wide_held: got we=%b a=%0d d=%h want 1/2/00a5", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; y = 16'(i); dest = 3'(i);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_cmp++;
            if (rf_we !== 1'b1 || rf_waddr !== 3'(i) || rf_wdata !== 16'(i)) begin
                n_bad++; $display("FAIL b2b_write[%0d]: got we=%b a=%0d d=%h want 1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, i, i);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] fl_before;
        idle_inputs();
        fl_before = {flag_c, flag_z, flag_v, flag_n};
        in_valid = 1'b1; y = 16'h5555; yhigh = 16'hAAAA; dest = 3'd5; use32bit = 1'b1;
        tick();
        idle_inputs();
        in_valid = 1'b1; flush = 1'b1; flags_we = 1'b1; co = 1'b1; zero = 1'b1; dest = 3'd1; y = 16'h0BAD;
        #1;
        n_cmp++;
        if (rf_we !== 1'b1 || rf_wdata !== 16'h5555 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_lo: got we=%b d=%h rdy=%b want 1/5555/0", rf_we, rf_wdata, in_ready);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_wdata !== 16'h5555) begin
            n_bad++; $display("FAIL flush_cancel: got we=%b d=%h want 0/5555", rf_we, rf_wdata);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || {flag_c, flag_z, flag_v, flag_n} !== fl_before) begin
            n_bad++; $display("FAIL flush_after: got we=%b flags=%b want 0/%b", rf_we, {flag_c, flag_z, flag_v, flag_n}, fl_before);
        end
    endtask

    task automatic test_flags_hold();
        idle_inputs();
        in_valid = 1'b1; flags_we = 1'b1; co = 1'b0; zero = 1'b0; overflow = 1'b1; negative = 1'b1;
        y = 16'h0001; dest = 3'd6;
        tick();
        in_valid = 1'b1; flags_we = 1'b0; co = 1'b1; zero = 1'b1; overflow = 1'b0; negative = 1'b0;
        y = 16'h0000; dest = 3'd4;
        tick();
        idle_inputs();
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd4 || rf_wdata !== 16'h0000 || {flag_c, flag_z, flag_v, flag_n} !== 4'b0011) begin
            n_bad++; $display("FAIL flags_hold: got we=%b a=%0d flags=%b want 1/4/0011", rf_we, rf_waddr, {flag_c, flag_z, flag_v, flag_n});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 1'b1; flags_we = 1'b1; co = 1'b1; y = 16'h1111; yhigh = 16'h2222; dest = 3'd2; use32bit = 1'b1;
        tick();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (rf_we !== 1'b0 || {flag_c, flag_z, flag_v, flag_n} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_mid: got we=%b flags=%b want 0/0000", rf_we, {flag_c, flag_z, flag_v, flag_n});
        end
        @(posedge clk); #1 reset = 1'b0;
        tick();
        n_cmp++;
        if (rf_we !== 1'b0 || rf_wdata !== 16'h0000) begin
            n_bad++; $display("FAIL reset_mid_nohi: got we=%b d=%h want 0/0000", rf_we, rf_wdata);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            y        = 16'($urandom);
            yhigh    = 16'($urandom);
            dest     = 3'($urandom);
            use32bit = ($urandom_range(0, 2) == 0);
            flags_we = $urandom_range(0, 1) == 1;
            {co, zero, overflow, negative} = 4'($urandom);
            flush    = ($urandom_range(0, 9) == 0);
            #1;
            n_cmp++;
            if (in_ready !== model_ready()) begin
                n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, model_ready());
            end
            tick();
            n_cmp++;
            if (rf_we !== exp_we || rf_waddr !== exp_addr || rf_wdata !== exp_data ||
                {flag_c, flag_z, flag_v, flag_n} !== exp_flags) begin
                n_bad++;
                $display("FAIL rand_port[%0d]: got we=%b a=%0d d=%h f=%b want we=%b a=%0d d=%h f=%b", c,
                         rf_we, rf_waddr, rf_wdata, {flag_c, flag_z, flag_v, flag_n},
                         exp_we, exp_addr, exp_data, exp_flags);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wide_wrap();
        test_back_to_back();
        test_flush();
        test_flags_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the 16-bit ALU. Registers the ALU result and flags, then drives the single register-file write port.
- A 16-bit result takes one write cycle. A 32-bit result (yhigh:y) takes two: low word to dest, high word to dest+1.
- Holds the architectural flag register (C, Z, V, N) that feeds branch logic and the ALU carry-in.

Parameters:
N, 16, data width of ALU result words
A, 3, register-file address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  ALU result presented this cycle
in_ready  output  1  stage can accept a result this cycle (combinational)
y  input  N  ALU low result word
yhigh  input  N  ALU high result word
co  input  1  ALU carry out
zero  input  1  ALU zero flag
overflow  input  1  ALU overflow flag
negative  input  1  ALU negative flag
use32bit  input  1  result is 32-bit; write yhigh to dest+1
dest  input  A  destination register index
flags_we  input  1  update flag register on acceptance
flush  input  1  synchronous cancel of any pending write
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  A  register-file write address (registered)
rf_wdata  output  N  register-file write data (registered)
flag_c  output  1  carry flag (registered)
flag_z  output  1  zero flag (registered)
flag_v  output  1  overflow flag (registered)
flag_n  output  1  negative flag (registered)

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset values: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0; all four flags=0; hi buffer and pend32 cleared.
- Handshake: a result is accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE: no write this cycle.
  - WR_LO: rf_we=1, low word.
  - WR_HI: rf_we=1, high word.
- in_ready = !flush && !(state==WR_LO && pend32). The stage accepts back-to-back 16-bit results at one per cycle. A 32-bit result blocks input for exactly one cycle.
- Acceptance at edge T:
  - Next state is WR_LO.
  - rf_waddr<=dest, rf_wdata<=y, rf_we<=1.
  - pend32<=use32bit; hi buffer<=yhigh; hi address<=dest+1, modulo 2^A.
  - The write is visible during cycle T+1, so latency is 1 cycle.
- From WR_LO:
  - pend32=1: next state WR_HI. rf_waddr<=hi address, rf_wdata<=hi buffer, rf_we<=1. The high write is visible in cycle T+2.
  - pend32=0 and a new acceptance: stay in WR_LO with the new data.
  - Otherwise: IDLE, rf_we<=0.
- From WR_HI: new acceptance goes to WR_LO; otherwise IDLE.
- Address wrap: dest=2^A-1 with use32bit writes the high word to register 0.
- Flags: on acceptance with flags_we=1, {flag_c,flag_z,flag_v,flag_n}<={co,zero,overflow,negative} at the same edge. The new flags are visible in cycle T+1. With flags_we=0, flags hold.
- Flags are updated once per accepted result, never on the WR_HI cycle.
- flush=1 at an edge:
  - No acceptance; in_ready=0.
  - Next state IDLE, rf_we<=0, pend32<=0.
  - A write already registered (visible this cycle) still completes. Only future writes, including a pending high word, are cancelled. Flags hold.
- Reset asserted mid-operation: all state clears immediately and the pending high word is lost.
- rf_waddr and rf_wdata hold their last value while rf_we=0.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- With the macro defined, add output ports fwd_valid (1), fwd_addr (A) and fwd_data (N). They are combinational copies of rf_we, rf_waddr and rf_wdata, exported so the operand stage can forward a write in the same cycle.
- Also with the macro defined, add output fwd_pend_hi (1), high when state==WR_LO && pend32. It tells the hazard logic that the hi address is still unwritten.
- Without the macro: these ports do not exist and there is no extra logic.

Test Plan:
1. Reset asserted, then released. -> rf_we=0, flags=0000, in_ready=1.
2. Single 16-bit accept: y=0x1234, dest=3, flags_we=1, co=1, zero=0, overflow=0, negative=0. -> Next cycle: rf_we=1, rf_waddr=3, rf_wdata=0x1234, flags CZVN=1000. Following cycle: rf_we=0.
3. 32-bit accept: yhigh=0xFFFF, y=0x8000, dest=7. -> Cycle +1: write 0x8000 to reg 7, in_ready=0. Cycle +2: write 0xFFFF to reg 0 (wrap), in_ready=1.
4. Back-to-back 16-bit, in_valid held for 4 cycles with y=1,2,3,4 and dest=1..4. -> Four consecutive rf_we cycles with the matching addr/data, no bubbles, in_ready=1 throughout.
5. flush in the WR_LO cycle of a 32-bit result. -> Low write completes, high write never issued, state IDLE, flags unchanged.
6. Accept with flags_we=0, zero=1. -> Register written, flags keep their previous value. Reset asserted during WR_LO of a 32-bit result -> rf_we=0 immediately, no high write.
